// File: rtl/rom_bus_ctl.sv
// ROM bus controller: captures the 8-bit fetch address from the A1/A2 phases, matches the chip id in A3,
// and drives the OPR/OPA nibbles in M1/M2. Defining ROM_PHASE_CHECK_EN adds the sticky PHASE_ERR checker.
//
// state   | meaning
// WAIT_A1 | idle, waiting for an A1 strobe to start an instruction cycle
// GOT_A1  | low address nibble captured, expecting A2
// GOT_A2  | full address captured, expecting A3 with the chip number
// SEL     | this chip selected, drives the bus in M1 and M2
// IDLE_X  | another chip selected or fetch finished, waiting for the next A1
module rom_bus_ctl #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       M1,
    input  logic       M2,
    input  logic       X1,
    input  logic       X2,
    input  logic       X3,
    input  logic       SYNC_N,
    input  logic [3:0] D_IN,
    output logic [3:0] D_OUT,
    output logic       D_OE,
    output logic [7:0] ROM_ADDR,
    output logic       ROM_RD,
    input  logic [7:0] ROM_DATA,
    output logic       PHASE_ERR
);

    typedef enum logic [2:0] {
        WAIT_A1 = 3'd0,
        GOT_A1  = 3'd1,
        GOT_A2  = 3'd2,
        SEL     = 3'd3,
        IDLE_X  = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] addr, addr_nxt;
    logic [3:0] opa, opa_nxt;
    logic       sel, sel_nxt;
    logic       chip_match;
    logic       any_strobe;

    assign chip_match = (D_IN == CHIP_ID);
    // A1 is handled ahead of the per-state decode, so it is excluded here
    assign any_strobe = A2 | A3 | M1 | M2 | X1 | X2 | X3;
    assign ROM_ADDR   = addr;

`ifdef ROM_PHASE_CHECK_EN
    logic [7:0] phases;
    logic       one_hot;
    logic       phase_fault;
    logic       sync_prev_low;
    logic       err_q;

    assign phases      = {X3, X2, X1, M2, M1, A3, A2, A1};
    assign one_hot     = (phases != 8'h00) && ((phases & (phases - 8'd1)) == 8'h00);
    assign phase_fault = !one_hot || (A1 && !sync_prev_low);
    assign PHASE_ERR   = err_q;

    always_ff @(posedge CLK) begin
        if (RES) begin
            err_q         <= 1'b0;
            sync_prev_low <= 1'b0;
        end else begin
            err_q         <= err_q | phase_fault;
            sync_prev_low <= ~SYNC_N;
        end
    end
`else
    logic sync_n_unused;

    assign sync_n_unused = SYNC_N;
    assign PHASE_ERR     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= WAIT_A1;
            addr  <= 8'h00;
            opa   <= 4'h0;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            opa   <= opa_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        opa_nxt   = opa;
        sel_nxt   = sel;
        ROM_RD    = 1'b0;
        D_OE      = 1'b0;
        D_OUT     = 4'h0;

        if (sel && M1) begin
            D_OE    = 1'b1;
            D_OUT   = ROM_DATA[7:4];
            opa_nxt = ROM_DATA[3:0];
        end else if (sel && M2) begin
            D_OE  = 1'b1;
            D_OUT = opa;
        end

        if (state == GOT_A2 && A3 && chip_match) begin
            ROM_RD = 1'b1;
        end

        if (A1) begin
            addr_nxt[3:0] = D_IN;
            state_nxt     = GOT_A1;
            sel_nxt       = 1'b0;
        end else begin
            case (state)
                GOT_A1: begin
                    if (A2) begin
                        addr_nxt[7:4] = D_IN;
                        state_nxt     = GOT_A2;
                    end else if (any_strobe) begin
                        state_nxt = WAIT_A1;
                        sel_nxt   = 1'b0;
                    end
                end
                GOT_A2: begin
                    if (A3) begin
                        if (chip_match) begin
                            sel_nxt   = 1'b1;
                            state_nxt = SEL;
                        end else begin
                            state_nxt = IDLE_X;
                        end
                    end else if (any_strobe) begin
                        state_nxt = WAIT_A1;
                        sel_nxt   = 1'b0;
                    end
                end
                SEL: begin
                    if (M2) begin
                        sel_nxt   = 1'b0;
                        state_nxt = IDLE_X;
                    end else if (M1) begin
                        state_nxt = SEL;
                    end else if (any_strobe) begin
                        state_nxt = WAIT_A1;
                        sel_nxt   = 1'b0;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end

`ifdef ROM_PHASE_CHECK_EN
        // a malformed phase pattern aborts the fetch even if A1 is present
        if (phase_fault) begin
            state_nxt = WAIT_A1;
            sel_nxt   = 1'b0;
        end
`endif
    end

endmodule
